// File: rtl/emmc_pkg.sv
// rtl/emmc_pkg.sv - shared eMMC data-path encodings and defaults
package emmc_pkg;

    localparam int WORD_W_DEF = 32;

    // SD bus width encodings as seen on bus_mode; 2'b11 behaves as 8-bit.
    typedef enum logic [1:0] {
        MODE_1BIT     = 2'b00,
        MODE_4BIT     = 2'b01,
        MODE_8BIT     = 2'b10,
        MODE_8BIT_ALT = 2'b11
    } bus_mode_e;

    // Number of beats needed to assemble one word in the given bus mode.
    function automatic int unsigned beats_per_word(input logic [1:0] mode,
                                                   input int unsigned word_w);
        case (mode)
            MODE_1BIT: return word_w;
            MODE_4BIT: return word_w / 4;
            default:   return word_w / 8;
        endcase
    endfunction

endpackage

// File: rtl/emmc_sync_fifo.sv
// rtl/emmc_sync_fifo.sv - first-word-fall-through synchronous word FIFO
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   flush          synchronous clear of pointers and level (beats push/pop)
//   push, din      write request and word; ignored when full unless popped
//   pop            read request; ignored when empty
//   dout           head word, zero while empty
//   level          stored word count; full/empty status flags
module emmc_sync_fifo
    import emmc_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WORD_W-1:0]          din,
    input  logic                       pop,
    output logic [WORD_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr;
    logic              rd;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign rd = pop & ~empty;
    assign wr = push & (~full | rd);

    // Gating on empty keeps dout at zero out of reset without clearing storage.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/emmc_dat_pack_fifo.sv
// rtl/emmc_dat_pack_fifo.sv - SD data lane packer feeding a word FIFO
//
// Ports:
//   aclk, rst            clock and asynchronous active-high reset
//   bus_mode             SD bus width (1/4/8-bit), sampled at word boundaries
//   sd_wr_en, sd_dat     one lane beat, MSB-first within the word
//   flush                synchronous clear of packer, FIFO and overflow
//   axi_rd_en            pop the head word
//   axi_data_out/valid   FWFT head word and its valid flag
//   level, full, empty   FIFO status
//   overflow             sticky: a completed word was dropped
//   pack_busy            packer holds a partial word
module emmc_dat_pack_fifo
    import emmc_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 16
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic [1:0]             bus_mode,
    input  logic                   sd_wr_en,
    input  logic [7:0]             sd_dat,
    input  logic                   flush,
    input  logic                   axi_rd_en,
    output logic [WORD_W-1:0]      axi_data_out,
    output logic                   axi_valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic                   pack_busy
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [1:0]        mode_q;
    logic [1:0]        mode_eff;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W:0]   cat1;
    logic [WORD_W+3:0] cat4;
    logic [WORD_W+7:0] cat8;
    logic              last_beat;
    logic              word_done;
    logic              drop;

    assign pack_busy = (cnt != '0);
    assign axi_valid = ~empty;

    // The first beat of a word uses the live bus_mode (it is latched on that
    // same edge); later beats use the latched copy so mid-word changes wait.
    assign mode_eff = pack_busy ? mode_q : bus_mode;

    assign cat1 = {sr, sd_dat[0]};
    assign cat4 = {sr, sd_dat[3:0]};
    assign cat8 = {sr, sd_dat};

    always_comb begin
        shifted = cat8[WORD_W-1:0];
        case (mode_eff)
            MODE_1BIT: shifted = cat1[WORD_W-1:0];
            MODE_4BIT: shifted = cat4[WORD_W-1:0];
            default:   shifted = cat8[WORD_W-1:0];
        endcase
    end

    assign last_beat = ((32'(cnt) + 32'd1) == beats_per_word(mode_eff, WORD_W));
    assign word_done = sd_wr_en & last_beat & ~flush;
    // A completed word is lost only when nothing leaves the full FIFO this cycle.
    assign drop      = word_done & full & ~axi_rd_en;

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_1BIT;
            cnt      <= '0;
            sr       <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            cnt      <= '0;
            sr       <= '0;
            overflow <= 1'b0;
        end else begin
            if (!pack_busy) mode_q <= bus_mode;
            if (sd_wr_en) begin
                if (last_beat) begin
                    cnt <= '0;
                    sr  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    sr  <= shifted;
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

    emmc_sync_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (rst),
        .flush (flush),
        .push  (word_done),
        .din   (shifted),
        .pop   (axi_rd_en),
        .dout  (axi_data_out),
        .level (level),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_emmc_dat_pack_fifo.sv
// tb/tb_emmc_dat_pack_fifo.sv - directed self-checking bench for emmc_dat_pack_fifo
module tb_emmc_dat_pack_fifo;

    logic        aclk = 1'b0;
    logic        rst;
    logic [1:0]  bus_mode;
    logic        sd_wr_en;
    logic [7:0]  sd_dat;
    logic        flush;
    logic        axi_rd_en;
    logic [31:0] axi_data_out;
    logic        axi_valid;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        pack_busy;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    emmc_dat_pack_fifo #(.WORD_W(32), .DEPTH(16)) dut (
        .aclk         (aclk),
        .rst          (rst),
        .bus_mode     (bus_mode),
        .sd_wr_en     (sd_wr_en),
        .sd_dat       (sd_dat),
        .flush        (flush),
        .axi_rd_en    (axi_rd_en),
        .axi_data_out (axi_data_out),
        .axi_valid    (axi_valid),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .pack_busy    (pack_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        sd_wr_en = 1'b1;
        sd_dat   = d;
        tick();
        sd_wr_en = 1'b0;
    endtask

    task automatic word8(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) beat(w[i*8 +: 8]);
    endtask

    task automatic pop1();
        axi_rd_en = 1'b1;
        tick();
        axi_rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus_mode = 2'b00; sd_wr_en = 1'b0; sd_dat = 8'h00;
        flush = 1'b0; axi_rd_en = 1'b0;
        tick(); tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_valid", 32'(axi_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(pack_busy), 32'd0);
        chk("rst_data", axi_data_out, 32'h0);
        rst = 1'b0;
        tick();

        // 8-bit mode
        bus_mode = 2'b10;
        beat(8'h12); beat(8'h34); beat(8'h56);
        chk("m8_busy", 32'(pack_busy), 32'd1);
        chk("m8_novalid", 32'(axi_valid), 32'd0);
        beat(8'h78);
        chk("m8_valid", 32'(axi_valid), 32'd1);
        chk("m8_data", axi_data_out, 32'h12345678);
        chk("m8_idle", 32'(pack_busy), 32'd0);
        tick();
        chk("m8_hold", axi_data_out, 32'h12345678);
        pop1();
        chk("m8_empty", 32'(empty), 32'd1);

        // 4-bit mode, upper nibble garbage must be ignored
        bus_mode = 2'b01;
        beat(8'hFA); beat(8'h5B); beat(8'h0C); beat(8'h3D);
        beat(8'h01); beat(8'hE2); beat(8'h03); beat(8'h74);
        chk("m4_data", axi_data_out, 32'hABCD1234);
        pop1();

        // 1-bit mode, only bit 0 counts
        bus_mode = 2'b00;
        for (int i = 0; i < 32; i++) beat((i % 2 == 0) ? 8'h01 : 8'hFE);
        chk("m1_data", axi_data_out, 32'hAAAAAAAA);
        chk("m1_level", 32'(level), 32'd1);
        pop1();

        // overflow: 16 words, then a 17th dropped
        bus_mode = 2'b10;
        for (int k = 1; k <= 16; k++) word8({4{8'(k)}});
        chk("of_full", 32'(full), 32'd1);
        chk("of_ovf0", 32'(overflow), 32'd0);
        word8(32'h11111111);
        chk("of_level", 32'(level), 32'd16);
        chk("of_ovf1", 32'(overflow), 32'd1);
        chk("of_head", axi_data_out, 32'h01010101);
        chk("of_busy", 32'(pack_busy), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            chk($sformatf("of_pop%0d", k), axi_data_out, {4{8'(k)}});
            pop1();
        end
        chk("of_empty", 32'(empty), 32'd1);
        chk("of_sticky", 32'(overflow), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("of_clear", 32'(overflow), 32'd0);

        // push and pop at full in the same cycle
        for (int k = 1; k <= 16; k++) word8({4{8'(k + 32)}});
        beat(8'h31); beat(8'h31); beat(8'h31);
        axi_rd_en = 1'b1;
        beat(8'h31);
        axi_rd_en = 1'b0;
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_head", axi_data_out, 32'h22222222);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("pp_flushed", 32'(level), 32'd0);

        // mode change mid-word takes effect at the next word
        bus_mode = 2'b10;
        beat(8'hAA); beat(8'hBB);
        bus_mode = 2'b00;
        beat(8'hCC); beat(8'hDD);
        chk("mc_level1", 32'(level), 32'd1);
        chk("mc_word1", axi_data_out, 32'hAABBCCDD);
        for (int i = 0; i < 4; i++) beat((i % 2 == 0) ? 8'hF1 : 8'h0E);
        chk("mc_still1", 32'(level), 32'd1);
        chk("mc_busy", 32'(pack_busy), 32'd1);
        for (int i = 4; i < 32; i++) beat((i % 2 == 0) ? 8'hF1 : 8'h0E);
        chk("mc_level2", 32'(level), 32'd2);
        pop1();
        chk("mc_word2", axi_data_out, 32'hAAAAAAAA);
        pop1();

        // flush with concurrent write and read
        bus_mode = 2'b10;
        word8(32'h01020304); word8(32'h05060708); word8(32'h090A0B0C);
        beat(8'hEE); beat(8'hEF);
        chk("fl_pre", 32'(level), 32'd3);
        flush = 1'b1; axi_rd_en = 1'b1;
        beat(8'hF0);
        flush = 1'b0; axi_rd_en = 1'b0;
        chk("fl_level", 32'(level), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_busy", 32'(pack_busy), 32'd0);
        chk("fl_valid", 32'(axi_valid), 32'd0);
        word8(32'hCAFEF00D);
        chk("fl_next", axi_data_out, 32'hCAFEF00D);
        chk("fl_next_lvl", 32'(level), 32'd1);

        // asynchronous reset mid-word
        word8(32'h55667788);
        beat(8'h99); beat(8'h98);
        rst = 1'b1;
        #2;
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_busy", 32'(pack_busy), 32'd0);
        chk("ar_data", axi_data_out, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        word8(32'h0BADBEEF);
        chk("ar_next", axi_data_out, 32'h0BADBEEF);
        chk("ar_next_lvl", 32'(level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/emmc_dat_pack_fifo.md
EMMC_DAT_PACK_FIFO -- requirements
Module: emmc_dat_pack_fifo

Interface
REQ-001 SHALL have parameter WORD_W, default 32: packed word width; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO depth in words; must be a power of 2 and at least 2.
REQ-003 SHALL have port aclk, input, 1: the single clock; all logic is rising-edge on aclk.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port bus_mode, input, 2: SD bus width; 00 = 1-bit, 01 = 4-bit, 10 = 8-bit, 11 = treated as 8-bit.
REQ-006 SHALL have port sd_wr_en, input, 1: one SD data beat is present on sd_dat.
REQ-007 SHALL have port sd_dat, input, 8: lane data; 1-bit mode uses [0], 4-bit mode uses [3:0], 8-bit mode uses [7:0].
REQ-008 SHALL have port flush, input, 1: synchronous clear of the packer, FIFO and overflow flag.
REQ-009 SHALL have port axi_rd_en, input, 1: consumer pops the head word.
REQ-010 SHALL have port axi_data_out, output, WORD_W: head word, first-word-fall-through.
REQ-011 SHALL have port axi_valid, output, 1: head word is valid (equal to !empty).
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1: number of stored words.
REQ-013 SHALL have ports full and empty, output, 1 each: FIFO status.
REQ-014 SHALL have port overflow, output, 1: sticky flag, set when a completed word is dropped.
REQ-015 SHALL have port pack_busy, output, 1: the packer holds a partial word.

Function
REQ-016 SHALL shift data MSB-first: the first beat of a word occupies the most-significant bits of that word.
REQ-017 SHALL latch bus_mode only while the packer is empty; a mode change mid-word SHALL take effect at the next word boundary.
REQ-018 SHALL complete a word after WORD_W/1, WORD_W/4 or WORD_W/8 beats, according to the latched mode.
REQ-019 SHALL push a completed word into the FIFO on the edge that accepts its last beat; the word SHALL appear on axi_data_out, with axi_valid high, on the following cycle when the FIFO was empty.
REQ-020 SHALL, when a word completes while the FIFO is full and no pop occurs that cycle, drop the word, set overflow, and return the packer to empty.
REQ-021 SHALL accept a push to a full FIFO if a pop occurs in the same cycle; level SHALL be unchanged.
REQ-022 SHALL ignore axi_rd_en while empty; pointers and level SHALL stay unchanged.
REQ-023 SHALL hold axi_data_out stable while axi_valid=1 and axi_rd_en=0.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; full = (level==DEPTH), empty = (level==0).
REQ-025 SHALL give flush priority over every same-cycle write and read: level becomes 0 and pack_busy and overflow go low on the next cycle.
REQ-026 SHALL clear overflow only by flush or rst.

Reset
REQ-027 SHALL, on rst, asynchronously set level=0, empty=1, full=0, axi_valid=0, overflow=0, pack_busy=0, axi_data_out=0, and the latched mode to 1-bit.
REQ-028 SHALL discard any partial word or stored words when rst is asserted mid-operation; the first beat after release SHALL start a new word.

Structure
REQ-029 SHALL take the bus_mode encodings and the WORD_W default from shared package emmc_pkg.
REQ-030 SHALL implement storage, pointers and level in sub-module emmc_sync_fifo (parameters WORD_W and DEPTH); the packer logic stays in the top module.

Verification
REQ-031 SHALL cover 8-bit mode: beats 0x12, 0x34, 0x56, 0x78 -> axi_data_out = 0x12345678 with axi_valid high one cycle after the 4th beat.
REQ-032 SHALL cover 4-bit mode: 8 nibbles 0xA,0xB,0xC,0xD,0x1,0x2,0x3,0x4 -> 0xABCD1234; 1-bit mode: 32 beats of an alternating 1,0 pattern -> 0xAAAAAAAA.
REQ-033 SHALL cover overflow: fill 16 words without reading, then complete a 17th -> level=16, overflow=1, head unchanged; 16 pops then return words 1..16 in order.
REQ-034 SHALL cover a push and pop at full in the same cycle -> level stays 16 and overflow stays 0.
REQ-035 SHALL cover a mode change after 2 beats in 8-bit mode -> the current word completes in 8-bit mode and the new mode applies from the next word.
REQ-036 SHALL cover flush asserted with a concurrent write and read while 3 words plus a partial word are held -> next cycle level=0, empty=1, pack_busy=0; likewise rst asserted mid-word.
